run_ctrl: RTL and testbench

//  Run/stop sequencer for the model CPU. Produces the fetch/execute state bit `sm` that the

---
 rtl/run_ctrl.sv | 120 ++++++++++++
 tb/tb_run_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run/stop sequencer for the model CPU.
// Drives the fetch/execute bit (sm) and a one-hot beat train for the
// control-signal decoder. It supports free run, stop at an instruction
// boundary, single-step from the front panel, and a sticky halt.
module run_ctrl #(
    parameter int T_BEATS = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               step_mode,
    input  logic               step_btn,
    input  logic               halt,
    output logic               sm,
    output logic [T_BEATS-1:0] beat,
    output logic               cyc_en,
    output logic               wr_stb,
    output logic               running,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_cnt
);

    localparam int BW = $clog2(T_BEATS);
    localparam logic [BW-1:0] LAST_B = BW'(T_BEATS - 1);
    localparam logic [T_BEATS-1:0] BEAT_ONE = {{(T_BEATS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        PAUSE,
        HALT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] b;
    logic [BW-1:0] b_next;
    logic          stop_req;
    logic          stop_req_next;
    logic          step_prev;
    logic          step_edge;
    logic          cycling;
    logic          last_beat;

    assign cycling   = (state == FETCH) || (state == EXEC);
    assign last_beat = cycling && (b == LAST_B);
    assign step_edge = step_btn & ~step_prev;

    // Next-state logic: sequencing decisions are made at instruction boundaries
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FETCH;
            FETCH: if (last_beat) state_next = EXEC;
            EXEC: begin
                if (last_beat) begin
                    if (halt)
                        state_next = HALT;
                    else if (stop_req || stop || step_mode)
                        state_next = PAUSE;
                    else
                        state_next = FETCH;
                end
            end
            PAUSE: begin
                if (step_edge || (start && !step_mode && !stop))
                    state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Beat counter restarts on every state change; stop request is latched while cycling
    always_comb begin
        b_next        = '0;
        stop_req_next = stop_req;
        if (state_next == state && cycling)
            b_next = b + BW'(1);
        if (state_next != state &&
            (state_next == PAUSE || state_next == IDLE || state_next == HALT))
            stop_req_next = 1'b0;
        else if (cycling && stop)
            stop_req_next = 1'b1;
    end

    // State, beat counter, stop latch and button history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            b         <= '0;
            stop_req  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            state     <= state_next;
            b         <= b_next;
            stop_req  <= stop_req_next;
            step_prev <= step_btn;
        end
    end

    // Retired-instruction counter, bumped on the final execute beat and saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instr_cnt <= '0;
        else if (state == EXEC && last_beat && instr_cnt != {CNT_W{1'b1}})
            instr_cnt <= instr_cnt + CNT_W'(1);
    end

    assign sm      = (state == EXEC);
    assign beat    = cycling ? (BEAT_ONE << b) : '0;
    assign cyc_en  = cycling;
    assign wr_stb  = last_beat;
    assign running = cycling;
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed and randomized checks of run_ctrl against an
// instruction-level model. A second instance with a 4-bit counter
// exercises saturation.
module tb_run_ctrl;

    localparam int T = 4;
    localparam int W = 16;
    localparam int WS = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_HALT  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         step_mode = 1'b0;
    logic         step_btn = 1'b0;
    logic         halt = 1'b0;

    logic         sm, cyc_en, wr_stb, running, halted;
    logic [T-1:0] beat;
    logic [W-1:0] instr_cnt;
    logic         sm_s, cyc_en_s, wr_stb_s, running_s, halted_s;
    logic [T-1:0] beat_s;
    logic [WS-1:0] instr_cnt_s;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // Model state: mode plus position inside the 2*T-clock instruction
    int m_mode = M_IDLE;
    int m_pos  = 0;
    bit m_stop = 1'b0;
    bit m_prev = 1'b0;
    int m_cnt  = 0;

    run_ctrl #(.T_BEATS(T), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .step_mode(step_mode), .step_btn(step_btn), .halt(halt),
        .sm(sm), .beat(beat), .cyc_en(cyc_en), .wr_stb(wr_stb),
        .running(running), .halted(halted), .instr_cnt(instr_cnt)
    );

    run_ctrl #(.T_BEATS(T), .CNT_W(WS)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .step_mode(step_mode), .step_btn(step_btn), .halt(halt),
        .sm(sm_s), .beat(beat_s), .cyc_en(cyc_en_s), .wr_stb(wr_stb_s),
        .running(running_s), .halted(halted_s), .instr_cnt(instr_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_stop, input logic s_mode,
                                 input logic s_btn, input logic s_halt);
        start     = s_start;
        stop      = s_stop;
        step_mode = s_mode;
        step_btn  = s_btn;
        halt      = s_halt;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        applyStimulus(0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // Instruction-level reference model, advanced on each rising edge
    always @(posedge clk or negedge rst) begin
        bit edge_seen;
        if (!rst) begin
            m_mode = M_IDLE;
            m_pos  = 0;
            m_stop = 1'b0;
            m_prev = 1'b0;
            m_cnt  = 0;
        end else begin
            edge_seen = step_btn && !m_prev;
            m_prev    = step_btn;
            case (m_mode)
                M_IDLE: if (start) begin m_mode = M_RUN; m_pos = 0; end
                M_RUN: begin
                    if (stop) m_stop = 1'b1;
                    if (m_pos == 2*T-1) begin
                        m_cnt++;
                        if (halt) begin
                            m_mode = M_HALT; m_stop = 1'b0;
                        end else if (m_stop || step_mode) begin
                            m_mode = M_PAUSE; m_stop = 1'b0;
                        end else begin
                            m_pos = 0;
                        end
                    end else begin
                        m_pos++;
                    end
                end
                M_PAUSE: begin
                    if (edge_seen || (start && !step_mode && !stop)) begin
                        m_mode = M_RUN; m_pos = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare both instances against the model on every falling edge
    always @(negedge clk) begin
        logic          e_run, e_sm, e_wr;
        logic [T-1:0]  e_beat;
        int            e_full, e_sat;
        if (cmp_en) begin
            e_run  = (m_mode == M_RUN);
            e_sm   = e_run && (m_pos >= T);
            e_wr   = e_run && ((m_pos % T) == T-1);
            e_beat = e_run ? T'(1 << (m_pos % T)) : '0;
            e_full = (m_cnt > 65535) ? 65535 : m_cnt;
            e_sat  = (m_cnt > 15) ? 15 : m_cnt;
            checkOutput("sm", sm, e_sm);
            checkOutput("beat", beat, e_beat);
            checkOutput("cyc_en", cyc_en, e_run);
            checkOutput("wr_stb", wr_stb, e_wr);
            checkOutput("running", running, e_run);
            checkOutput("halted", halted, m_mode == M_HALT);
            checkOutput("instr_cnt", instr_cnt, e_full);
            checkOutput("sat_beat", beat_s, e_beat);
            checkOutput("sat_halted", halted_s, m_mode == M_HALT);
            checkOutput("sat_instr_cnt", instr_cnt_s, e_sat);
        end
    end

    // Directed scenarios followed by a randomized run
    initial begin
        int wr_count;
        int run_count;
        int hold;

        do_reset();
        cmp_en = 1'b1;

        // Free run: beat train, counter and write strobe cadence
        applyStimulus(1, 0, 0, 0, 0);
        tick(1);
        for (int i = 0; i < 2*T; i++) begin
            checkOutput("run_beat", beat, 1 << (i % T));
            checkOutput("run_sm", sm, (i >= T) ? 1 : 0);
            tick(1);
        end
        checkOutput("run_cnt_1", instr_cnt, 1);
        wr_count = 0;
        for (int i = 0; i < 16; i++) begin
            if (wr_stb) wr_count++;
            tick(1);
        end
        checkOutput("run_wr_count", wr_count, 4);
        checkOutput("run_cnt_3", instr_cnt, 3);

        // Asynchronous reset in the middle of an execute beat
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        tick(1);
        tick(6);
        checkOutput("pre_rst_beat", beat, 4'b0100);
        checkOutput("pre_rst_sm", sm, 1);
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_sm", sm, 0);
        checkOutput("rst_beat", beat, 0);
        checkOutput("rst_cnt", instr_cnt, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        tick(3);
        checkOutput("rst_idle", running, 0);

        // Halt on the last execute beat of the second instruction
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        tick(1);
        tick(15);
        checkOutput("halt_pre_beat", beat, 4'b1000);
        applyStimulus(1, 0, 0, 1, 1);
        tick(1);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_cnt", instr_cnt, 2);
        applyStimulus(1, 0, 0, 0, 0);
        tick(4);
        checkOutput("halt_sticky", halted, 1);
        checkOutput("halt_not_run", running, 0);

        // Single-step: one instruction, then three button presses
        do_reset();
        applyStimulus(1, 0, 1, 0, 0);
        tick(1);
        start = 1'b0;
        tick(7);
        tick(1);
        checkOutput("step_paused", running, 0);
        checkOutput("step_cnt_1", instr_cnt, 1);
        for (int p = 0; p < 3; p++) begin
            run_count = 0;
            step_btn = 1'b1;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                if (i == 4) step_btn = 1'b0;
                if (running) run_count++;
            end
            checkOutput("step_run_clocks", run_count, 8);
        end
        checkOutput("step_cnt_4", instr_cnt, 4);

        // One-clock stop pulse during fetch beat 1
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        tick(1);
        start = 1'b0;
        tick(1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(6);
        checkOutput("stop_paused", running, 0);
        checkOutput("stop_cnt", instr_cnt, 1);
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        checkOutput("stop_resume_beat", beat, 4'b0001);
        checkOutput("stop_resume_sm", sm, 0);

        // Saturation of the narrow counter; halt during fetch is ignored
        do_reset();
        applyStimulus(1, 0, 0, 0, 0);
        tick(1);
        start = 1'b0;
        tick(160);
        checkOutput("sat_cnt_15", instr_cnt_s, 15);
        checkOutput("full_cnt_20", instr_cnt, 20);
        halt = 1'b1;
        tick(4);
        halt = 1'b0;
        checkOutput("fetch_halt_sm", sm, 1);
        tick(4);
        checkOutput("fetch_halt_running", running, 1);
        checkOutput("fetch_halt_halted", halted, 0);
        checkOutput("fetch_halt_cnt", instr_cnt, 21);

        // Randomized run against the model
        do_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
            end else begin
                start = ($urandom_range(0, 99) < 15);
                stop  = ($urandom_range(0, 99) < 4);
                halt  = ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 49) == 0) step_mode = ~step_mode;
                if (hold == 0) begin
                    step_btn = ~step_btn;
                    hold = $urandom_range(1, 12);
                end else begin
                    hold--;
                end
                tick(1);
            end
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
